// File: rtl/ps2_pkg.sv
// ============================================================================
// Module  : ps2_pkg
// Brief   : Shared PS/2 types and constants: transmitter state encoding,
//           keyboard command bytes and the odd-parity frame helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RTS   = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    localparam int FILTER_TAPS = 8;

    // Nine-bit shift image: odd parity bit above the data byte, LSB first on the wire.
    function automatic logic [8:0] ps2_frame(input logic [7:0] data);
        return {~^data, data};
    endfunction

endpackage : ps2_pkg

`default_nettype wire

// File: rtl/ps2_clk_filter.sv
// ============================================================================
// Module  : ps2_clk_filter
// Brief   : PS/2 clock deglitcher. The filtered level changes only after
//           TAPS identical samples; a one-cycle tick marks each falling edge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_clk_filter #(
    parameter int TAPS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c_in,
    output logic fall
);

    logic [TAPS-1:0] r_shift;
    logic            r_filt;
    logic            w_filt_next;

    // Idle bus level is high, so start from an all-ones history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '1;
            r_filt  <= 1'b1;
        end else begin
            r_shift <= {ps2c_in, r_shift[TAPS-1:1]};
            r_filt  <= w_filt_next;
        end
    end

    always_comb begin
        w_filt_next = r_filt;
        if (&r_shift) begin
            w_filt_next = 1'b1;
        end else if (~|r_shift) begin
            w_filt_next = 1'b0;
        end
    end

    assign fall = r_filt & ~w_filt_next;

endmodule : ps2_clk_filter

`default_nettype wire

// File: rtl/ps2_tx.sv
// ============================================================================
// Module  : ps2_tx
// Brief   : Host-to-device PS/2 transmitter: request-to-send, 8 data bits,
//           odd parity, stop bit and device acknowledge check. Optional
//           frame watchdog enabled by defining PS2_TX_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int RTS_US      = 100,
    parameter int TIMEOUT_MS  = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_ack_err,
    output logic       tx_timeout
);

    localparam int c_rts_cycles = CLK_FREQ_HZ / 1_000_000 * RTS_US;
    localparam int c_rts_w      = (c_rts_cycles > 1) ? $clog2(c_rts_cycles) : 1;
    localparam logic [c_rts_w-1:0] c_rts_load = c_rts_w'(c_rts_cycles - 1);

    if (c_rts_cycles < 1 || TIMEOUT_MS < 1) begin : g_param_check
        $error("ps2_tx: request-to-send and timeout intervals must be at least one cycle");
    end

    ps2_tx_state_t      r_state;
    ps2_tx_state_t      w_state_next;
    logic [c_rts_w-1:0] r_rts_cnt;
    logic [c_rts_w-1:0] w_rts_cnt_next;
    logic [8:0]         r_bits;
    logic [8:0]         w_bits_next;
    logic [3:0]         r_nbits;
    logic [3:0]         w_nbits_next;
    logic               r_done;
    logic               w_done_next;
    logic               r_ack_err;
    logic               w_ack_err_next;
    logic               w_c_low;
    logic               w_d_low;
    logic               w_fall;

    ps2_clk_filter #(
        .TAPS    (FILTER_TAPS)
    ) u_clk_filter (
        .clk     (clk),
        .reset   (reset),
        .ps2c_in (ps2c),
        .fall    (w_fall)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int c_wdog_limit = CLK_FREQ_HZ / 1000 * TIMEOUT_MS;
    localparam int c_wdog_w     = (c_wdog_limit > 1) ? $clog2(c_wdog_limit) : 1;
    localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(c_wdog_limit - 1);

    logic [c_wdog_w-1:0] r_wdog;
    logic [c_wdog_w-1:0] w_wdog_next;
    logic                r_timeout;
    logic                w_timeout_next;
    logic                w_frame_active;

    assign w_frame_active = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP);

    // Counts device silence; any falling edge proves the device is still clocking.
    always_comb begin
        w_wdog_next = '0;
        if (w_frame_active && !w_fall) begin
            w_wdog_next = r_wdog + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wdog    <= w_wdog_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign tx_timeout = r_timeout;
`else
    assign tx_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_rts_cnt <= '0;
            r_bits    <= '0;
            r_nbits   <= '0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rts_cnt <= w_rts_cnt_next;
            r_bits    <= w_bits_next;
            r_nbits   <= w_nbits_next;
            r_done    <= w_done_next;
            r_ack_err <= w_ack_err_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_rts_cnt_next = r_rts_cnt;
        w_bits_next    = r_bits;
        w_nbits_next   = r_nbits;
        w_done_next    = 1'b0;
        w_ack_err_next = r_ack_err;
        w_c_low        = 1'b0;
        w_d_low        = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
        w_timeout_next = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (wr_ps2) begin
                    w_bits_next    = ps2_frame(din);
                    w_rts_cnt_next = c_rts_load;
                    w_state_next   = ST_RTS;
                end
            end
            ST_RTS: begin
                w_c_low = 1'b1;
                if (r_rts_cnt == '0) begin
                    w_state_next = ST_START;
                end else begin
                    w_rts_cnt_next = r_rts_cnt - 1'b1;
                end
            end
            ST_START: begin
                w_d_low = 1'b1;
                if (w_fall) begin
                    w_nbits_next = 4'd8;
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                w_d_low = ~r_bits[0];
                if (w_fall) begin
                    if (r_nbits != 4'd0) begin
                        w_bits_next  = {1'b0, r_bits[8:1]};
                        w_nbits_next = r_nbits - 1'b1;
                    end else begin
                        w_state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // Line released: the host stop bit is the pull-up, then the device acks low.
                if (w_fall) begin
                    w_ack_err_next = ps2d;
                    w_done_next    = 1'b1;
                    w_state_next   = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        if (w_frame_active && !w_fall && (r_wdog == c_wdog_last)) begin
            w_state_next   = ST_IDLE;
            w_done_next    = 1'b0;
            w_ack_err_next = r_ack_err;
            w_timeout_next = 1'b1;
        end
`endif
    end

    // Drive enables decode the asynchronously reset state, so reset frees the bus at once.
    assign ps2c = w_c_low ? 1'b0 : 1'bz;
    assign ps2d = w_d_low ? 1'b0 : 1'bz;

    assign tx_idle      = (r_state == ST_IDLE);
    assign tx_done_tick = r_done;
    assign tx_ack_err   = r_ack_err;

endmodule : ps2_tx

`default_nettype wire

// File: tb/tb_ps2_tx.sv
// ============================================================================
// Module  : tb_ps2_tx
// Brief   : Directed bench for ps2_tx with a simple PS/2 device model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    wire        ps2c;
    wire        ps2d;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_ack_err;
    logic       tx_timeout;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int tmo_cnt = 0;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    ps2_tx dut (
        .clk          (clk),
        .reset        (reset),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick),
        .tx_ack_err   (tx_ack_err),
        .tx_timeout   (tx_timeout)
    );

    always @(posedge clk) begin
        if (reset && tx_done_tick) done_cnt <= done_cnt + 1;
        if (reset && tx_timeout)   tmo_cnt  <= tmo_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        din    = b;
        wr_ps2 = 1'b1;
        cyc(1);
        wr_ps2 = 1'b0;
    endtask

    task automatic wait_rts(output int low_cnt);
        int t;
        t = 0;
        while (ps2c !== 1'b0 && t < 10) begin
            cyc(1);
            t++;
        end
        low_cnt = 0;
        while (ps2c === 1'b0 && low_cnt < 20000) begin
            low_cnt++;
            cyc(1);
        end
    endtask

    // Device side of one frame: 11 clock pulses of 40 clk, data sampled just before each fall.
    task automatic dev_frame(input bit ack, input int wr_at, input int glitch_at,
                             output logic [10:0] bits);
        cyc(20);
        for (int i = 0; i < 11; i++) begin
            bits[i] = ps2d;
            if (i == 10 && ack) begin
                dev_d_low = 1'b1;
                cyc(2);
            end
            dev_c_low = 1'b1;
            if (i == wr_at) begin
                din    = 8'hFF;
                wr_ps2 = 1'b1;
                cyc(1);
                wr_ps2 = 1'b0;
                cyc(19);
            end else begin
                cyc(20);
            end
            dev_c_low = 1'b0;
            if (i == glitch_at) begin
                cyc(10);
                dev_c_low = 1'b1;
                cyc(3);
                dev_c_low = 1'b0;
                cyc(7);
            end else begin
                cyc(20);
            end
        end
        dev_d_low = 1'b0;
        cyc(20);
    endtask

    initial begin
        logic [10:0] bits;
        int          low_cnt;
        int          d0;
        int          t0;
        int          lows;

        // Reset state
        cyc(5);
        check("rst_idle",    tx_idle,      1'b1);
        check("rst_done",    tx_done_tick, 1'b0);
        check("rst_ack_err", tx_ack_err,   1'b0);
        check("rst_timeout", tx_timeout,   1'b0);
        check("rst_ps2c",    ps2c,         1'b1);
        check("rst_ps2d",    ps2d,         1'b1);
        reset = 1'b1;
        cyc(20);

        // 1: set-LEDs command, acknowledged
        d0 = done_cnt;
        send(8'hED);
        check("t1_busy", tx_idle, 1'b0);
        wait_rts(low_cnt);
        check("t1_rts_cycles", low_cnt, 10000);
        dev_frame(1'b1, -1, -1, bits);
        check("t1_bits", bits, 11'b1_1_11101101_0);
        check("t1_done", done_cnt - d0, 1);
        check("t1_ack_err", tx_ack_err, 1'b0);
        check("t1_idle", tx_idle, 1'b1);

        // 2: zero byte, device withholds ack
        d0 = done_cnt;
        send(8'h00);
        wait_rts(low_cnt);
        dev_frame(1'b0, -1, -1, bits);
        check("t2_bits", bits, 11'b1_1_00000000_0);
        check("t2_done", done_cnt - d0, 1);
        check("t2_ack_err", tx_ack_err, 1'b1);

        // 3: second write mid-frame is ignored
        d0 = done_cnt;
        send(8'hED);
        wait_rts(low_cnt);
        dev_frame(1'b1, 4, -1, bits);
        check("t3_bits", bits, 11'b1_1_11101101_0);
        check("t3_done", done_cnt - d0, 1);
        check("t3_ack_err", tx_ack_err, 1'b0);
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            if (ps2c === 1'b0) lows++;
            cyc(1);
        end
        check("t3_no_rts", lows, 0);
        check("t3_idle", tx_idle, 1'b1);

        // 4: short clock glitch during data phase
        d0 = done_cnt;
        send(8'hFF);
        wait_rts(low_cnt);
        dev_frame(1'b1, -1, 5, bits);
        check("t4_bits", bits, 11'b1_1_11111111_0);
        check("t4_done", done_cnt - d0, 1);
        check("t4_ack_err", tx_ack_err, 1'b0);

        // 5: asynchronous reset mid-frame
        d0 = done_cnt;
        send(8'h00);
        wait_rts(low_cnt);
        cyc(20);
        for (int i = 0; i < 3; i++) begin
            dev_c_low = 1'b1;
            cyc(20);
            dev_c_low = 1'b0;
            cyc(20);
        end
        check("t5_data_driven", ps2d, 1'b0);
        reset = 1'b0;
        #1;
        check("t5_ps2c_released", ps2c, 1'b1);
        check("t5_ps2d_released", ps2d, 1'b1);
        check("t5_idle", tx_idle, 1'b1);
        cyc(3);
        reset = 1'b1;
        cyc(50);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_idle_after", tx_idle, 1'b1);

        // 6: silent device
        d0 = done_cnt;
        t0 = tmo_cnt;
        send(8'hED);
        wait_rts(low_cnt);
`ifdef PS2_TX_TIMEOUT_EN
        lows = 0;
        while (tmo_cnt == t0 && lows < 2_100_000) begin
            cyc(1);
            lows++;
        end
        check("t6_timeout_pulse", tmo_cnt - t0, 1);
        check("t6_timeout_window", (lows >= 1_999_000 && lows <= 2_001_000), 1'b1);
        cyc(2);
        check("t6_ps2c", ps2c, 1'b1);
        check("t6_ps2d", ps2d, 1'b1);
        check("t6_idle", tx_idle, 1'b1);
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_ack_err_kept", tx_ack_err, 1'b0);
`else
        cyc(3000);
        check("t6_no_timeout", tmo_cnt - t0, 0);
        check("t6_timeout_low", tx_timeout, 1'b0);
        check("t6_stuck_busy", tx_idle, 1'b0);
        check("t6_start_held", ps2d, 1'b0);
        check("t6_no_done", done_cnt - d0, 0);
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(2);
        check("t6_recover_idle", tx_idle, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ps2_tx

`default_nettype wire
